ddr3_dfi_mem: RTL and testbench

Synthesisable DFI-side responder that stands in for the DDR3 PHY plus SDRAM at the controller's DFI boundary. It decodes the command bus, tracks the open row per bank, captures write bursts into an internal RAM and returns read bursts with a fixed latency on `dfi_rvld`/`dfi_last`/`dfi_data`. It is the target for controller-level simulation and on-FPGA loopback testing without external memory, and optionally flags protocol violations.

---
 rtl/ddr3_dfi_mem_if.sv | 38 +++
 rtl/ddr3_dfi_mem.sv | 254 +++++++++++++++++++++++++
 tb/tb_ddr3_dfi_mem.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_dfi_mem_if.sv
// DFI command/write/read bundle between a DDR3 controller (master) and its PHY+SDRAM stand-in (slave).
// Pure wiring: no latency, no flow control beyond the DFI timing contract itself.
interface ddr3_dfi_mem_if #(
  parameter int DDR_ROW_BITS = 15,
  parameter int DFI_DQ_WIDTH = 32,
  parameter int DFI_DM_WIDTH = 4
);
  logic                    dfi_rst_ni;
  logic                    dfi_cke_i;
  logic                    dfi_cs_ni;
  logic                    dfi_ras_ni;
  logic                    dfi_cas_ni;
  logic                    dfi_we_ni;
  logic                    dfi_odt_i;
  logic [2:0]              dfi_bank_i;
  logic [DDR_ROW_BITS-1:0] dfi_addr_i;
  logic                    dfi_wstb_i;
  logic                    dfi_wren_i;
  logic [DFI_DM_WIDTH-1:0] dfi_mask_i;
  logic [DFI_DQ_WIDTH-1:0] dfi_data_i;
  logic                    dfi_rden_i;
  logic                    dfi_rvld_o;
  logic                    dfi_last_o;
  logic [DFI_DQ_WIDTH-1:0] dfi_data_o;
  logic [3:0]              err_o;

  modport master (
    output dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i,
           dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i, dfi_data_i, dfi_rden_i,
    input  dfi_rvld_o, dfi_last_o, dfi_data_o, err_o
  );

  modport slave (
    input  dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni, dfi_odt_i,
           dfi_bank_i, dfi_addr_i, dfi_wstb_i, dfi_wren_i, dfi_mask_i, dfi_data_i, dfi_rden_i,
    output dfi_rvld_o, dfi_last_o, dfi_data_o, err_o
  );
endinterface

// File: rtl/ddr3_dfi_mem.sv
// DFI-side DDR3 PHY+SDRAM responder backed by an internal RAM; DDR3_DFI_MEM_CHECKS_EN adds err_o checks.
// Latency: READ at edge T returns 4 registered beats at T+RD_LATENCY..T+RD_LATENCY+3.
// No backpressure: overlapping read bursts and write overflow/underflow are dropped (and flagged).
module ddr3_dfi_mem #(
  parameter int DDR_ROW_BITS  = 15,
  parameter int DDR_COL_BITS  = 10,
  parameter int DFI_DQ_WIDTH  = 32,
  parameter int DFI_DM_WIDTH  = 4,
  parameter int PHY_BURSTLEN  = 4,
  parameter int RD_LATENCY    = 4,
  parameter int MEM_ADDR_BITS = 10
) (
  input  logic          clock,
  input  logic          reset,
  ddr3_dfi_mem_if.slave dfi
);

  localparam int BEAT_BITS = $clog2(PHY_BURSTLEN);
  localparam int BASE_W    = MEM_ADDR_BITS - BEAT_BITS;
  localparam int FULL_W    = 3 + DDR_ROW_BITS + DDR_COL_BITS - BEAT_BITS;
  localparam int BYTE_W    = DFI_DQ_WIDTH / DFI_DM_WIDTH;
  localparam int WQ_DEPTH  = 4;
  localparam int DL_LEN    = RD_LATENCY - 1;
  localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(PHY_BURSTLEN - 1);

  typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;

  logic                     cmd_en;
  logic [2:0]               cmd;
  logic                     is_act, is_rd, is_wr, is_pre;
  logic [DDR_ROW_BITS-1:0]  bank_row [8];
  logic [FULL_W-1:0]        cmd_full;
  logic [BASE_W-1:0]        cmd_base;

  logic [DFI_DQ_WIDTH-1:0]  mem [MEM_DEPTH];

  logic [DL_LEN-1:0]        dl_vld;
  logic [BASE_W-1:0]        dl_base [DL_LEN];
  logic                     rd_start;
  logic [BASE_W-1:0]        rd_start_base;

  rd_state_t                rd_state, rd_state_nxt;
  logic [BEAT_BITS-1:0]     rd_beat, rd_beat_nxt;
  logic [BASE_W-1:0]        rd_base, rd_base_nxt;
  logic                     rd_fire, rd_fire_last, rd_overrun;
  logic [MEM_ADDR_BITS-1:0] rd_addr;
  logic [DFI_DQ_WIDTH-1:0]  rd_word;

  logic [BASE_W-1:0]        wq_mem [WQ_DEPTH];
  logic [1:0]               wq_rd_ptr, wq_wr_ptr;
  logic [2:0]               wq_cnt;
  logic                     wq_empty, wq_full, wq_push, wq_pop, wq_drop;
  logic                     wr_pop_head, wr_beat_ok, wr_underrun;
  logic [BEAT_BITS-1:0]     wr_beat;
  logic [BASE_W-1:0]        wr_base;
  logic [MEM_ADDR_BITS-1:0] wr_addr;

  logic                     rvld_q, last_q;
  logic [DFI_DQ_WIDTH-1:0]  data_q;

  logic                     unused_sig;

  // ---------------- command decode and row tracking ----------------
  assign cmd_en = dfi.dfi_rst_ni && dfi.dfi_cke_i && !dfi.dfi_cs_ni;
  assign cmd    = {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni};
  assign is_act = cmd_en && (cmd == 3'b011);
  assign is_rd  = cmd_en && (cmd == 3'b101);
  assign is_wr  = cmd_en && (cmd == 3'b100);
  assign is_pre = cmd_en && (cmd == 3'b010);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bank_row[i] <= '0;
    end else if (is_act) begin
      bank_row[dfi.dfi_bank_i] <= dfi.dfi_addr_i;
    end
  end

  // Only the low bits of the concatenated address index the RAM; upper bits alias.
  assign cmd_full = {dfi.dfi_bank_i, bank_row[dfi.dfi_bank_i],
                     dfi.dfi_addr_i[DDR_COL_BITS-1:BEAT_BITS]};
  assign cmd_base = cmd_full[BASE_W-1:0];

  // ---------------- write address FIFO ----------------
  assign wq_empty    = (wq_cnt == 3'd0);
  assign wq_full     = (wq_cnt == 3'(WQ_DEPTH));
  assign wr_pop_head = dfi.dfi_wren_i && !wq_empty && (wr_beat == LAST_BEAT);
  assign wq_push     = is_wr && (!wq_full || wr_pop_head);
  assign wq_drop     = is_wr && !wq_push;
  assign wr_beat_ok  = dfi.dfi_wren_i && (!wq_empty || wq_push);
  assign wr_underrun = dfi.dfi_wren_i && !wr_beat_ok;
  assign wq_pop      = wr_beat_ok && (wr_beat == LAST_BEAT);
  // An empty FIFO lets a same-cycle WRITE supply the beat address directly.
  assign wr_base     = wq_empty ? cmd_base : wq_mem[wq_rd_ptr];
  assign wr_addr     = {wr_base, wr_beat};

  always_ff @(posedge clock) begin
    if (reset) begin
      wq_rd_ptr <= '0;
      wq_wr_ptr <= '0;
      wq_cnt    <= '0;
      wr_beat   <= '0;
    end else begin
      if (wq_push) wq_wr_ptr <= wq_wr_ptr + 2'd1;
      if (wq_pop)  wq_rd_ptr <= wq_rd_ptr + 2'd1;
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt <= wq_cnt + 3'd1;
        2'b01:   wq_cnt <= wq_cnt - 3'd1;
        default: wq_cnt <= wq_cnt;
      endcase
      if (wr_beat_ok) wr_beat <= (wr_beat == LAST_BEAT) ? '0 : wr_beat + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wq_push) wq_mem[wq_wr_ptr] <= cmd_base;
  end

  always_ff @(posedge clock) begin
    if (!reset && wr_beat_ok) begin
      for (int b = 0; b < DFI_DM_WIDTH; b++) begin
        if (!dfi.dfi_mask_i[b]) mem[wr_addr][b*BYTE_W +: BYTE_W] <= dfi.dfi_data_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // ---------------- read delay line ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      dl_vld <= '0;
    end else begin
      for (int i = DL_LEN - 1; i > 0; i--) dl_vld[i] <= dl_vld[i-1];
      dl_vld[0] <= is_rd;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = DL_LEN - 1; i > 0; i--) dl_base[i] <= dl_base[i-1];
    dl_base[0] <= cmd_base;
  end

  assign rd_start      = dl_vld[DL_LEN-1];
  assign rd_start_base = dl_base[DL_LEN-1];

  // ---------------- read burst generator ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      rd_beat  <= '0;
      rd_base  <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      rd_beat  <= rd_beat_nxt;
      rd_base  <= rd_base_nxt;
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_beat_nxt  = rd_beat;
    rd_base_nxt  = rd_base;
    case (rd_state)
      RD_IDLE: begin
        if (rd_start) begin
          rd_state_nxt = RD_BURST;
          rd_beat_nxt  = '0;
          rd_base_nxt  = rd_start_base;
        end
      end
      RD_BURST: begin
        if (rd_beat == LAST_BEAT) begin
          // A start landing on the final beat chains gaplessly.
          rd_state_nxt = rd_start ? RD_BURST : RD_IDLE;
          rd_beat_nxt  = '0;
          if (rd_start) rd_base_nxt = rd_start_base;
        end else begin
          rd_beat_nxt = rd_beat + 1'b1;
        end
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    rd_fire      = (rd_state == RD_BURST);
    rd_fire_last = rd_fire && (rd_beat == LAST_BEAT);
    rd_overrun   = rd_start && rd_fire && (rd_beat != LAST_BEAT);
  end

  assign rd_addr = {rd_base, rd_beat};

  // Write-before-read: a beat written on the capturing edge is forwarded.
  always_comb begin
    rd_word = mem[rd_addr];
    if (wr_beat_ok && (wr_addr == rd_addr)) begin
      for (int b = 0; b < DFI_DM_WIDTH; b++) begin
        if (!dfi.dfi_mask_i[b]) rd_word[b*BYTE_W +: BYTE_W] = dfi.dfi_data_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rvld_q <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
    end else begin
      rvld_q <= rd_fire;
      last_q <= rd_fire_last;
      data_q <= rd_fire ? rd_word : '0;
    end
  end

  assign dfi.dfi_rvld_o = rvld_q;
  assign dfi.dfi_last_o = last_q;
  assign dfi.dfi_data_o = data_q;

  // ---------------- protocol checks ----------------
`ifdef DDR3_DFI_MEM_CHECKS_EN
  logic [7:0] bank_open;
  logic [3:0] err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      bank_open <= '0;
    end else if (is_act) begin
      bank_open[dfi.dfi_bank_i] <= 1'b1;
    end else if (is_pre) begin
      if (dfi.dfi_addr_i[10]) bank_open <= '0;
      else                    bank_open[dfi.dfi_bank_i] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | {wq_drop || wr_underrun,
                        rd_overrun,
                        is_act && bank_open[dfi.dfi_bank_i],
                        (is_rd || is_wr) && !bank_open[dfi.dfi_bank_i]};
    end
  end

  assign dfi.err_o = err_q;
  assign unused_sig = ^{dfi.dfi_odt_i, dfi.dfi_wstb_i, dfi.dfi_rden_i, cmd_full};
`else
  assign dfi.err_o = '0;
  assign unused_sig = ^{dfi.dfi_odt_i, dfi.dfi_wstb_i, dfi.dfi_rden_i, cmd_full,
                        is_pre, rd_overrun, wq_drop, wr_underrun};
`endif

endmodule

// File: tb/tb_ddr3_dfi_mem.sv
// Bench for ddr3_dfi_mem: directed test-plan steps then randomized traffic, checked every cycle
// against a queue/array reference model of the DFI memory.
module tb_ddr3_dfi_mem;
  localparam int RL = 4;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_PRE = 3'b010, C_NOP = 3'b111;
`ifdef DDR3_DFI_MEM_CHECKS_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ddr3_dfi_mem_if #(.DDR_ROW_BITS(15), .DFI_DQ_WIDTH(32), .DFI_DM_WIDTH(4)) dfi ();

  ddr3_dfi_mem #(
    .DDR_ROW_BITS(15), .DDR_COL_BITS(10), .DFI_DQ_WIDTH(32), .DFI_DM_WIDTH(4),
    .PHY_BURSTLEN(4), .RD_LATENCY(RL), .MEM_ADDR_BITS(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dfi(dfi)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vld_cnt, last_cnt;

  // Reference model state
  typedef struct { int start; int unsigned base; } burst_t;
  logic [31:0] mmem [1024];
  int unsigned m_row [8];
  bit          m_open [8];
  int unsigned wq[$];
  int          m_wbeat;
  burst_t      bq[$];
  int          busy_end;
  logic [3:0]  m_err;
  logic        exp_vld, exp_last;
  logic [31:0] exp_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    wq.delete();
    bq.delete();
    m_wbeat  = 0;
    busy_end = -100;
    m_err    = '0;
    for (int b = 0; b < 8; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = 0;
    end
    exp_vld = 1'b0; exp_last = 1'b0; exp_data = '0;
  endfunction

  // One clock edge of the spec's behaviour, evaluated on the inputs sampled at that edge.
  function automatic void model_edge();
    int unsigned b, a, base, wa;
    int st, k;
    logic [2:0] c;
    cyc++;
    if (reset) begin
      model_reset();
      return;
    end
    b = int'(dfi.dfi_bank_i);
    a = int'(dfi.dfi_addr_i);
    c = {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni};
    base = (((b << 15) | m_row[b]) << 8) | ((a % 1024) >> 2);
    if (dfi.dfi_rst_ni && dfi.dfi_cke_i && !dfi.dfi_cs_ni) begin
      case (c)
        C_ACT: begin
          if (m_open[b]) m_err[1] = 1'b1;
          m_open[b] = 1'b1;
          m_row[b]  = a;
        end
        C_PRE: begin
          if (a & 32'h400) for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
          else m_open[b] = 1'b0;
        end
        C_RD: begin
          if (!m_open[b]) m_err[0] = 1'b1;
          st = cyc + RL;
          if (st <= busy_end) m_err[2] = 1'b1;
          else begin
            bq.push_back('{st, base});
            busy_end = st + 3;
          end
        end
        C_WR: begin
          if (!m_open[b]) m_err[0] = 1'b1;
          if (wq.size() < 4 || (dfi.dfi_wren_i && wq.size() > 0 && m_wbeat == 3)) wq.push_back(base);
          else m_err[3] = 1'b1;
        end
        default: ;
      endcase
    end
    if (dfi.dfi_wren_i) begin
      if (wq.size() == 0) m_err[3] = 1'b1;
      else begin
        wa = (wq[0] * 4 + m_wbeat) % 1024;
        for (int i = 0; i < 4; i++)
          if (!dfi.dfi_mask_i[i]) mmem[wa][i*8 +: 8] = dfi.dfi_data_i[i*8 +: 8];
        if (m_wbeat == 3) begin
          void'(wq.pop_front());
          m_wbeat = 0;
        end else m_wbeat++;
      end
    end
    exp_vld = 1'b0; exp_last = 1'b0; exp_data = '0;
    if (bq.size() > 0 && bq[0].start <= cyc) begin
      k = cyc - bq[0].start;
      exp_vld  = 1'b1;
      exp_last = (k == 3);
      exp_data = mmem[(bq[0].base * 4 + k) % 1024];
      if (k == 3) void'(bq.pop_front());
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("rvld", {31'b0, dfi.dfi_rvld_o}, {31'b0, exp_vld});
    chk("last", {31'b0, dfi.dfi_last_o}, {31'b0, exp_last});
    chk("data", dfi.dfi_data_o, exp_data);
    chk("err",  {28'b0, dfi.err_o}, {28'b0, (CHK_EN ? m_err : 4'b0)});
    if (dfi.dfi_rvld_o) vld_cnt++;
    if (dfi.dfi_last_o) last_cnt++;
    {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = C_NOP;
    dfi.dfi_cs_ni  = 1'b0;
    dfi.dfi_wren_i = 1'b0;
    dfi.dfi_mask_i = '0;
    dfi.dfi_data_i = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_cmd(input logic [2:0] code, input int b, input int a);
    {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = code;
    dfi.dfi_bank_i = 3'(b);
    dfi.dfi_addr_i = 15'(a);
  endtask

  task automatic act(input int b, input int row);
    set_cmd(C_ACT, b, row);
    tick();
  endtask

  task automatic rd(input int b, input int col);
    set_cmd(C_RD, b, col);
    tick();
  endtask

  // WRITE with beat 0 in the same cycle, beats 1..3 on the following cycles.
  task automatic wr_burst(input int b, input int col, input logic [127:0] d, input logic [15:0] m);
    set_cmd(C_WR, b, col);
    for (int k = 0; k < 4; k++) begin
      dfi.dfi_wren_i = 1'b1;
      dfi.dfi_data_i = d[k*32 +: 32];
      dfi.dfi_mask_i = m[k*4 +: 4];
      tick();
    end
  endtask

  initial begin
    logic [31:0] tp [4];
    int r;
    bit wr_now;
    reset = 1'b1;
    dfi.dfi_rst_ni = 1'b1; dfi.dfi_cke_i = 1'b1; dfi.dfi_cs_ni = 1'b0;
    {dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni} = C_NOP;
    dfi.dfi_odt_i = 1'b0; dfi.dfi_wstb_i = 1'b0; dfi.dfi_rden_i = 1'b0;
    dfi.dfi_bank_i = '0; dfi.dfi_addr_i = '0;
    dfi.dfi_wren_i = 1'b0; dfi.dfi_mask_i = '0; dfi.dfi_data_i = '0;
    for (int i = 0; i < 1024; i++) mmem[i] = 'x;
    model_reset();
    idle(3);
    reset = 1'b0;

    // Basic write then read
    act(0, 5);
    wr_burst(0, 8, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 16'h0);
    rd(0, 8);
    idle(3);
    tp[0] = 32'h1111_1111; tp[1] = 32'h2222_2222; tp[2] = 32'h3333_3333; tp[3] = 32'h4444_4444;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tp_rvld", {31'b0, dfi.dfi_rvld_o}, 32'd1);
      chk("tp_data", dfi.dfi_data_o, tp[k]);
      chk("tp_last", {31'b0, dfi.dfi_last_o}, (k == 3) ? 32'd1 : 32'd0);
    end
    chk("tp_err", {28'b0, dfi.err_o}, 32'd0);
    idle(2);

    // Byte-masked overwrite
    wr_burst(0, 16, {4{32'hAAAA_AAAA}}, 16'h0);
    wr_burst(0, 16, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 16'h0030);
    rd(0, 16);
    idle(4);
    tick();
    chk("mask_beat1", dfi.dfi_data_o, 32'h2222_AAAA);
    idle(3);

    // Back-to-back reads 4 apart, then 2 apart
    vld_cnt = 0; last_cnt = 0;
    rd(0, 8); idle(3); rd(0, 16); idle(10);
    chk("gapless_beats", vld_cnt, 32'd8);
    chk("gapless_lasts", last_cnt, 32'd2);
    vld_cnt = 0; last_cnt = 0;
    rd(0, 16); idle(1); rd(0, 8); idle(10);
    chk("overrun_beats", vld_cnt, 32'd4);
    chk("overrun_err", {31'b0, dfi.err_o[2]}, {31'b0, CHK_EN});

    // Protocol violations
    rd(3, 8); idle(8);
    chk("closed_err", {31'b0, dfi.err_o[0]}, {31'b0, CHK_EN});
    act(1, 7); act(1, 9);
    chk("act_open_err", {31'b0, dfi.err_o[1]}, {31'b0, CHK_EN});
    dfi.dfi_wren_i = 1'b1; dfi.dfi_data_i = 32'hDEAD_BEEF;
    tick();
    chk("underrun_err", {31'b0, dfi.err_o[3]}, {31'b0, CHK_EN});

    // Reset in the middle of a burst
    rd(0, 8);
    idle(5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_rvld", {31'b0, dfi.dfi_rvld_o}, 32'd0);
    chk("rst_data", dfi.dfi_data_o, 32'd0);
    chk("rst_err", {28'b0, dfi.err_o}, 32'd0);
    act(0, 5);
    wr_burst(0, 8, {32'h8888_8888, 32'h7777_7777, 32'h6666_6666, 32'h5555_5555}, 16'h0);
    rd(0, 8);
    idle(8);

    // Preload every RAM word, then random traffic
    for (int b = 0; b < 8; b++) act(b, $urandom_range(32767));
    for (int c = 0; c < 256; c++)
      wr_burst($urandom_range(7), c * 4, {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      wr_now = 1'b0;
      reset = ($urandom_range(399) == 0);
      if (r < 25) set_cmd(C_RD, $urandom_range(7), $urandom_range(32767));
      else if (r < 40) begin
        set_cmd(C_WR, $urandom_range(7), $urandom_range(32767));
        wr_now = 1'b1;
      end
      else if (r < 43) set_cmd(C_ACT, $urandom_range(7), $urandom_range(32767));
      else if (r < 45) set_cmd(C_PRE, $urandom_range(7), $urandom_range(32767));
      dfi.dfi_cs_ni  = ($urandom_range(9) == 0);
      dfi.dfi_wren_i = (wq.size() > 0 || wr_now) ? ($urandom_range(3) != 0) : ($urandom_range(29) == 0);
      dfi.dfi_mask_i = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0;
      dfi.dfi_data_i = $urandom();
      tick();
    end
    reset = 1'b0;
    idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
